vdma_init_sequencer: RTL and testbench

VDMA_INIT_SEQUENCER -- requirements
Module: vdma_init_sequencer

---
 rtl/vdma_pkg.sv | 25 ++
 rtl/vdma_init_rom.sv | 27 ++
 rtl/vdma_init_sequencer.sv | 144 ++++++++++++++
 tb/tb_vdma_init_sequencer.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/vdma_pkg.sv
// vdma_pkg: shared states, VDMA register offsets, AXI response codes and error codes
package vdma_pkg;
`ifdef VDMA_SEQ_STATUS_POLL_EN
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_RSP, POLL_ISSUE, POLL_WAIT, DONE, ERR} state_t;
`else
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_RSP, DONE, ERR} state_t;
`endif
  localparam logic [7:0] VDMACR = 8'h00;
  localparam logic [7:0] VDMASR = 8'h04;
  localparam logic [7:0] VSIZE_R = 8'h50;
  localparam logic [7:0] HSIZE_R = 8'h54;
  localparam logic [7:0] STRIDE_R = 8'h58;
  localparam logic [7:0] START1 = 8'h5C;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_RESP = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [2:0] LAST_IDX = 3'd4;
  function automatic logic resp_is_err(input logic [1:0] r);
    return r == RESP_SLVERR || r == RESP_DECERR;
  endfunction
endpackage

// File: rtl/vdma_init_rom.sv
// vdma_init_rom: combinational table of the five VDMA setup writes
module vdma_init_rom
  import vdma_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter logic [31:0] FRAME_BASE = 32'h1000_0000,
  parameter int HSIZE = 3200,
  parameter int STRIDE = 3200,
  parameter int VSIZE = 600
) (
  input  logic [2:0] idx,
  output logic [AXI_ADDR_WIDTH-1:0] addr,
  output logic [AXI_DATA_WIDTH-1:0] data
);
  // run/circular control first, then frame address and geometry, VSIZE last since it arms the channel
  always_comb begin
    addr = idx == 3'd0 ? AXI_ADDR_WIDTH'(VDMACR) :
           idx == 3'd1 ? AXI_ADDR_WIDTH'(START1) :
           idx == 3'd2 ? AXI_ADDR_WIDTH'(STRIDE_R) :
           idx == 3'd3 ? AXI_ADDR_WIDTH'(HSIZE_R) : AXI_ADDR_WIDTH'(VSIZE_R);
    data = idx == 3'd0 ? AXI_DATA_WIDTH'(32'h0000_0003) :
           idx == 3'd1 ? AXI_DATA_WIDTH'(FRAME_BASE) :
           idx == 3'd2 ? AXI_DATA_WIDTH'(STRIDE) :
           idx == 3'd3 ? AXI_DATA_WIDTH'(HSIZE) : AXI_DATA_WIDTH'(VSIZE);
  end
endmodule

// File: rtl/vdma_init_sequencer.sv
// vdma_init_sequencer: writes the VDMA MM2S setup table over a command channel; DMASR polling when VDMA_SEQ_STATUS_POLL_EN is defined
module vdma_init_sequencer
  import vdma_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter logic [31:0] FRAME_BASE = 32'h1000_0000,
  parameter int HSIZE = 3200,
  parameter int STRIDE = 3200,
  parameter int VSIZE = 600,
  parameter int POLL_LIMIT = 1024
) (
  input  logic M_AXI_ACLK,
  input  logic M_AXI_ARESETN,
  input  logic start,
  output logic cmd_valid,
  input  logic cmd_ready,
  output logic cmd_write,
  output logic [AXI_ADDR_WIDTH-1:0] cmd_addr,
  output logic [AXI_DATA_WIDTH-1:0] cmd_wdata,
  input  logic rsp_valid,
  input  logic [1:0] rsp_resp,
  input  logic [AXI_DATA_WIDTH-1:0] rsp_rdata,
  output logic busy,
  output logic done,
  output logic error,
  output logic [1:0] err_code
);
  state_t state;
  logic [2:0] idx;
  logic [2:0] rom_idx;
  logic [AXI_ADDR_WIDTH-1:0] rom_addr;
  logic [AXI_DATA_WIDTH-1:0] rom_data;
`ifdef VDMA_SEQ_STATUS_POLL_EN
  localparam int PW = $clog2(POLL_LIMIT + 1);
  logic [PW-1:0] poll_cnt;
`else
  logic unused_ok;
  assign unused_ok = ^{rsp_rdata, POLL_LIMIT != 0};
`endif
  // the ROM is addressed by the entry about to be loaded, so command outputs can be registered on entry to ISSUE
  assign rom_idx = (state == WAIT_RSP) ? idx + 3'd1 : 3'd0;
  vdma_init_rom #(
    .AXI_ADDR_WIDTH(AXI_ADDR_WIDTH), .AXI_DATA_WIDTH(AXI_DATA_WIDTH), .FRAME_BASE(FRAME_BASE),
    .HSIZE(HSIZE), .STRIDE(STRIDE), .VSIZE(VSIZE)
  ) u_rom (
    .idx(rom_idx), .addr(rom_addr), .data(rom_data)
  );
  // sequencer FSM; all outputs registered, one command outstanding at a time
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state <= IDLE;
      idx <= 3'd0;
      cmd_valid <= 1'b0;
      cmd_write <= 1'b0;
      cmd_addr <= '0;
      cmd_wdata <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
      err_code <= ERR_NONE;
`ifdef VDMA_SEQ_STATUS_POLL_EN
      poll_cnt <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= ISSUE;
          idx <= 3'd0;
          busy <= 1'b1;
          error <= 1'b0;
          err_code <= ERR_NONE;
          cmd_valid <= 1'b1;
          cmd_write <= 1'b1;
          cmd_addr <= rom_addr;
          cmd_wdata <= rom_data;
        end
        ISSUE: if (cmd_ready) begin
          cmd_valid <= 1'b0;
          state <= WAIT_RSP;
        end
        WAIT_RSP: if (rsp_valid) begin
          if (resp_is_err(rsp_resp)) begin
            state <= ERR;
            error <= 1'b1;
            err_code <= ERR_RESP;
          end else if (idx == LAST_IDX) begin
`ifdef VDMA_SEQ_STATUS_POLL_EN
            state <= POLL_ISSUE;
            poll_cnt <= '0;
            cmd_valid <= 1'b1;
            cmd_write <= 1'b0;
            cmd_addr <= AXI_ADDR_WIDTH'(VDMASR);
            cmd_wdata <= '0;
`else
            state <= DONE;
            done <= 1'b1;
`endif
          end else begin
            idx <= rom_idx;
            state <= ISSUE;
            cmd_valid <= 1'b1;
            cmd_addr <= rom_addr;
            cmd_wdata <= rom_data;
          end
        end
`ifdef VDMA_SEQ_STATUS_POLL_EN
        POLL_ISSUE: if (cmd_ready) begin
          cmd_valid <= 1'b0;
          state <= POLL_WAIT;
        end
        POLL_WAIT: if (rsp_valid) begin
          if (resp_is_err(rsp_resp)) begin
            state <= ERR;
            error <= 1'b1;
            err_code <= ERR_RESP;
          end else if (!rsp_rdata[0]) begin
            state <= DONE;
            done <= 1'b1;
          end else if (poll_cnt == PW'(POLL_LIMIT - 1)) begin
            state <= ERR;
            error <= 1'b1;
            err_code <= ERR_TIMEOUT;
          end else begin
            poll_cnt <= poll_cnt + 1'b1;
            state <= POLL_ISSUE;
            cmd_valid <= 1'b1;
          end
        end
`endif
        DONE: begin
          state <= IDLE;
          busy <= 1'b0;
        end
        ERR: begin
          state <= IDLE;
          busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vdma_init_sequencer.sv
// tb_vdma_init_sequencer: directed bench with a command-channel responder and hand-computed expectations
module tb_vdma_init_sequencer;
  logic M_AXI_ACLK = 1'b0;
  logic M_AXI_ARESETN = 1'b0;
  logic start = 1'b0;
  logic cmd_ready = 1'b0;
  logic rsp_valid = 1'b0;
  logic [1:0] rsp_resp = 2'b00;
  logic [31:0] rsp_rdata = '0;
  logic cmd_valid, cmd_write, busy, done, error;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [1:0] err_code;
  int errors = 0;
  int checks = 0;
  logic [31:0] la [32];
  logic [31:0] ld [32];
  logic lw [32];
  logic [31:0] cap_a, cap_d;
  logic cap_w, got_done, got_err;
  int ncmd, nwr, nrd, unstable, done_cyc, rsp_cyc, extra;
  logic [31:0] exp_a [5] = '{32'h00, 32'h5C, 32'h58, 32'h54, 32'h50};
  logic [31:0] exp_d [5] = '{32'h3, 32'h1000_0000, 32'hC80, 32'hC80, 32'h258};
`ifdef VDMA_SEQ_STATUS_POLL_EN
  localparam int NRD1 = 1;
`else
  localparam int NRD1 = 0;
`endif
  localparam int NC = 5 + NRD1;

  always #5 M_AXI_ACLK = ~M_AXI_ACLK;

  vdma_init_sequencer #(.POLL_LIMIT(4)) dut (
    .M_AXI_ACLK(M_AXI_ACLK), .M_AXI_ARESETN(M_AXI_ARESETN), .start(start),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid),
    .rsp_resp(rsp_resp), .rsp_rdata(rsp_rdata), .busy(busy), .done(done),
    .error(error), .err_code(err_code)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge M_AXI_ACLK);
    start = 1'b1;
    @(negedge M_AXI_ACLK);
    start = 1'b0;
  endtask

  task automatic serve(input int dly, input int bad_wr, input int halted, input int start_at, input int budget);
    int w;
    logic seen_v;
    ncmd = 0; nwr = 0; nrd = 0; unstable = 0; got_done = 0; got_err = 0;
    seen_v = 0; w = 0; done_cyc = -1; rsp_cyc = -1;
    for (int c = 0; c < budget; c++) begin
      @(negedge M_AXI_ACLK);
      rsp_valid = 1'b0;
      if (done) begin got_done = 1; done_cyc = c; break; end
      if (error) begin got_err = 1; break; end
      start = (c == start_at);
      if (cmd_ready) begin
        cmd_ready = 1'b0;
        seen_v = 0;
        if (cmd_valid) unstable++;
        if (ncmd < 32) begin la[ncmd] = cap_a; ld[ncmd] = cap_d; lw[ncmd] = cap_w; end
        ncmd++;
        rsp_valid = 1'b1;
        rsp_cyc = c;
        if (cap_w) begin
          nwr++;
          rsp_resp = (nwr == bad_wr) ? 2'b10 : 2'b00;
          rsp_rdata = '0;
        end else begin
          nrd++;
          rsp_resp = 2'b00;
          rsp_rdata = (nrd <= halted) ? 32'h1 : 32'h0;
        end
      end else if (cmd_valid) begin
        if (!seen_v) begin
          seen_v = 1; w = 0; cap_a = cmd_addr; cap_d = cmd_wdata; cap_w = cmd_write;
        end else if (cmd_addr !== cap_a || cmd_wdata !== cap_d || cmd_write !== cap_w) unstable++;
        if (w == dly) cmd_ready = 1'b1; else w++;
      end
    end
    start = 1'b0; rsp_valid = 1'b0; cmd_ready = 1'b0; rsp_resp = 2'b00;
  endtask

  task automatic idle_watch(input int n);
    extra = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge M_AXI_ACLK);
      if (cmd_valid || busy) extra++;
    end
  endtask

  task automatic check_table(input string tag);
    for (int i = 0; i < 5; i++) begin
      check({tag, "_addr"}, la[i], exp_a[i]);
      check({tag, "_data"}, ld[i], exp_d[i]);
      check({tag, "_wr"}, 32'(lw[i]), 32'h1);
    end
  endtask

  initial begin
    repeat (2) @(negedge M_AXI_ACLK);
    check("rst_valid", 32'(cmd_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_error", 32'(error), 0);
    check("rst_code", 32'(err_code), 0);
    check("rst_addr", cmd_addr, 0);
    M_AXI_ARESETN = 1'b1;
    // basic run, ready immediate
    pulse_start();
    check("t1_busy", 32'(busy), 1);
    check("t1_valid", 32'(cmd_valid), 1);
    check("t1_first_addr", cmd_addr, 0);
    serve(0, 0, 0, -1, 200);
    check("t1_done", 32'(got_done), 1);
    check("t1_ncmd", ncmd, NC);
    check("t1_nrd", nrd, NRD1);
    check_table("t1");
`ifdef VDMA_SEQ_STATUS_POLL_EN
    check("t1_rd_addr", la[5], 32'h04);
    check("t1_rd_wr", 32'(lw[5]), 0);
`endif
    check("t1_done_lat", done_cyc - rsp_cyc, 1);
    check("t1_stable", unstable, 0);
    @(negedge M_AXI_ACLK);
    check("t1_done_pulse", 32'(done), 0);
    check("t1_busy_end", 32'(busy), 0);
    // delayed ready, start pulsed while busy
    pulse_start();
    serve(3, 0, 0, 6, 400);
    check("t2_done", 32'(got_done), 1);
    check("t2_ncmd", ncmd, NC);
    check("t2_stable", unstable, 0);
    check_table("t2");
    idle_watch(6);
    check("t2_no_rerun", extra, 0);
    // error response on third write
    pulse_start();
    serve(0, 3, 0, -1, 200);
    check("t3_err", 32'(got_err), 1);
    check("t3_ncmd", ncmd, 3);
    check("t3_code", 32'(err_code), 1);
    idle_watch(6);
    check("t3_quiet", extra, 0);
    check("t3_sticky", 32'(error), 1);
    check("t3_code_held", 32'(err_code), 1);
    pulse_start();
    check("t3_clr_err", 32'(error), 0);
    check("t3_clr_code", 32'(err_code), 0);
    serve(0, 0, 0, -1, 200);
    check("t3_rerun_done", 32'(got_done), 1);
    check("t3_rerun_ncmd", ncmd, NC);
    // reset during second write
    pulse_start();
    serve(3, 0, 0, -1, 7);
    check("t4_pre_valid", 32'(cmd_valid), 1);
    check("t4_pre_addr", cmd_addr, 32'h5C);
    #2 M_AXI_ARESETN = 1'b0;
    #1;
    check("t4_valid_async", 32'(cmd_valid), 0);
    check("t4_busy_async", 32'(busy), 0);
    check("t4_addr_async", cmd_addr, 0);
    @(negedge M_AXI_ACLK);
    M_AXI_ARESETN = 1'b1;
    idle_watch(5);
    check("t4_no_reissue", extra, 0);
    pulse_start();
    serve(0, 0, 0, -1, 200);
    check("t4_done", 32'(got_done), 1);
    check("t4_ncmd", ncmd, NC);
    check_table("t4");
`ifdef VDMA_SEQ_STATUS_POLL_EN
    // halted three times then running
    pulse_start();
    serve(0, 0, 3, -1, 300);
    check("t5_done", 32'(got_done), 1);
    check("t5_nrd", nrd, 4);
    // always halted with POLL_LIMIT=4
    pulse_start();
    serve(0, 0, 100, -1, 300);
    check("t6_err", 32'(got_err), 1);
    check("t6_nrd", nrd, 4);
    check("t6_code", 32'(err_code), 2);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
